// File: rtl/rib_pkg.sv
// Shared RIB bus definitions: widths, default base address, responder FSM
// encoding and the latched request payload.
package rib_pkg;

  localparam int unsigned RIB_AW    = 32;
  localparam int unsigned RIB_DW    = 32;
  localparam int unsigned RIB_BEW   = RIB_DW / 8;
  localparam int unsigned RIB_WAITW = 4;

  localparam logic [RIB_AW-1:0] RIB_ADDR_BASE_DEFAULT = 32'h1000_0000;

  // Value driven on rib_err_o for an out-of-range access
  localparam logic RIB_ERR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rib_state_e;

  typedef struct packed {
    logic              we;
    logic [RIB_AW-1:0] addr;
    logic [RIB_DW-1:0] wdata;
    logic [RIB_BEW-1:0] be;
  } rib_req_t;

endpackage

// File: rtl/rib_ram_sp.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, per-byte write enable,
// registered read. Contents are not reset.
//   clk      clock
//   en_i     access enable (read or write this edge)
//   we_i     write enable (qualified by be_i lanes)
//   be_i     byte-lane enables
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data (old contents on a write)
module rib_ram_sp
  import rib_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDXW = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [RIB_BEW-1:0] be_i,
  input  logic [IDXW-1:0]    addr_i,
  input  logic [RIB_DW-1:0]  wdata_i,
  output logic [RIB_DW-1:0]  rdata_o
);

  logic [RIB_DW-1:0] mem_q [DEPTH_WORDS];

  // Byte-lane write plus registered read
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < int'(RIB_BEW); i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/rib_ram_responder.sv
// RIB bus responder backed by an on-chip word-addressed RAM with a fixed
// number of wait states between grant and response.
//   clk, rst      clock, synchronous active-high reset
//   rib_req_i     request valid (held until granted)
//   rib_we_i      1 = write, 0 = read
//   rib_addr_i    byte address
//   rib_wdata_i   write data
//   rib_be_i      byte enables
//   rib_gnt_o     request accepted this cycle (combinational in IDLE)
//   rib_rvalid_o  one-cycle response pulse
//   rib_rdata_o   read data, zero unless a successful read response
//   rib_err_o     out-of-range flag, valid with rib_rvalid_o
module rib_ram_responder
  import rib_pkg::*;
#(
  parameter logic [RIB_AW-1:0] ADDR_BASE   = RIB_ADDR_BASE_DEFAULT,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rib_req_i,
  input  logic               rib_we_i,
  input  logic [RIB_AW-1:0]  rib_addr_i,
  input  logic [RIB_DW-1:0]  rib_wdata_i,
  input  logic [RIB_BEW-1:0] rib_be_i,
  output logic               rib_gnt_o,
  output logic               rib_rvalid_o,
  output logic [RIB_DW-1:0]  rib_rdata_o,
  output logic               rib_err_o
);

  localparam int unsigned       IDXW = $clog2(DEPTH_WORDS);
  localparam logic [RIB_AW-1:0] SPAN = RIB_AW'(4 * DEPTH_WORDS);

  rib_state_e           state_q, state_d;
  logic [RIB_WAITW-1:0] cnt_q, cnt_d;
  rib_req_t             req_q, req_d;
  logic                 rvalid_q, err_q, rd_ok_q;

  rib_req_t          acc;
  logic [RIB_AW-1:0] acc_off;
  logic              acc_in_range;
  logic              ram_en;
  logic              ram_we;
  logic [RIB_DW-1:0] ram_rdata;

  // The RAM access on the edge into RESP uses the live request when coming
  // straight from IDLE (zero wait states), otherwise the latched one.
  always_comb begin
    acc = req_q;
    if (state_q == ST_IDLE) begin
      acc.we    = rib_we_i;
      acc.addr  = rib_addr_i;
      acc.wdata = rib_wdata_i;
      acc.be    = rib_be_i;
    end
  end

  assign acc_off      = acc.addr - ADDR_BASE;
  assign acc_in_range = (acc.addr >= ADDR_BASE) && (acc_off < SPAN);

  // Next-state, counter and grant
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rib_gnt_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rib_req_i) begin
          rib_gnt_o = 1'b1;
          req_d     = acc;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = RIB_WAITW'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - RIB_WAITW'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Reset aborts everything, including a grant in the same cycle
    if (rst) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      rib_gnt_o = 1'b0;
    end
  end

  // RESP is only ever entered from IDLE/WAIT, so this marks the entry edge
  assign ram_en = (state_d == ST_RESP);
  assign ram_we = acc.we && acc_in_range;

  // State and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rvalid_q <= ram_en;
      err_q    <= ram_en && !acc_in_range ? RIB_ERR : 1'b0;
      rd_ok_q  <= ram_en && acc_in_range && !acc.we;
    end
  end

  rib_ram_sp #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (acc.be),
    .addr_i  (acc_off[IDXW+1:2]),
    .wdata_i (acc.wdata),
    .rdata_o (ram_rdata)
  );

  assign rib_rvalid_o = rvalid_q;
  assign rib_err_o    = err_q;
  assign rib_rdata_o  = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_rib_ram_responder.sv
module tb_rib_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [3];
  logic        we     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  be     [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int WC [3] = '{1, 0, 3};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [32:0] sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rib_ram_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .rib_req_i(req[0]), .rib_we_i(we[0]), .rib_addr_i(addr[0]),
    .rib_wdata_i(wdata[0]), .rib_be_i(be[0]), .rib_gnt_o(gnt[0]), .rib_rvalid_o(rvalid[0]),
    .rib_rdata_o(rdata[0]), .rib_err_o(err[0]));

  rib_ram_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .rib_req_i(req[1]), .rib_we_i(we[1]), .rib_addr_i(addr[1]),
    .rib_wdata_i(wdata[1]), .rib_be_i(be[1]), .rib_gnt_o(gnt[1]), .rib_rvalid_o(rvalid[1]),
    .rib_rdata_o(rdata[1]), .rib_err_o(err[1]));

  rib_ram_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .rib_req_i(req[2]), .rib_we_i(we[2]), .rib_addr_i(addr[2]),
    .rib_wdata_i(wdata[2]), .rib_be_i(be[2]), .rib_gnt_o(gnt[2]), .rib_rvalid_o(rvalid[2]),
    .rib_rdata_o(rdata[2]), .rib_err_o(err[2]));

  // One request on instance d: push expectation at grant, pop at rvalid,
  // check data, error flag, latency and idle-zero outputs while waiting.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                     input string nm, output int gwait);
    int tg;
    bit got;
    logic [32:0] e;
    tg = 0; got = 0; gwait = 0;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt[d]) begin
        got = 1; tg = cyc; gwait = k;
        sb_q.push_back({exp_e, exp_d});
      end
      @(posedge clk); #1;
    end
    req[d] = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s gnt: no grant within 20 cycles", nm);
      return;
    end
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      checks++;
      if (rvalid[d]) begin
        got = 1;
        e = sb_q.pop_front();
        if (rdata[d] !== e[31:0]) begin
          failures++; $display("FAIL %s rdata got=%h exp=%h", nm, rdata[d], e[31:0]);
        end
        checks++;
        if (err[d] !== e[32]) begin
          failures++; $display("FAIL %s err got=%b exp=%b", nm, err[d], e[32]);
        end
        checks++;
        if (cyc - tg != 1 + WC[d]) begin
          failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, cyc - tg, 1 + WC[d]);
        end
      end else if (rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
        failures++; $display("FAIL %s idle_outputs rdata=%h err=%b exp 0/0", nm, rdata[d], err[d]);
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s rvalid: none within 30 cycles", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (gnt[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs inst%0d got gnt=%b rvalid=%b rdata=%h err=%b exp all 0",
                 d, gnt[d], rvalid[d], rdata[d], err[d]);
      end
    end
    req[0] = 1'b1; addr[0] = 32'h1000_0000;
    #1;
    checks++;
    if (gnt[0] !== 1'b0) begin
      failures++; $display("FAIL reset_req_no_gnt got=%b exp=0", gnt[0]);
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int gw;
    txn(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr_deadbeef", gw);
    txn(0, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, "rd_deadbeef", gw);
  endtask

  task automatic test_byte_lanes();
    int gw;
    txn(0, 1'b1, 32'h1000_0000, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "wr_word0", gw);
    txn(0, 1'b1, 32'h1000_0000, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, "wr_lanes", gw);
    txn(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, "rd_lanes", gw);
    txn(0, 1'b0, 32'h1000_0003, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, "rd_unaligned", gw);
  endtask

  task automatic test_out_of_range();
    int gw;
    txn(0, 1'b0, 32'h1000_1000, 32'h0, 4'hF, 32'h0, 1'b1, "rd_above", gw);
    txn(0, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, 32'h0, 1'b1, "rd_below", gw);
    txn(0, 1'b1, 32'h1000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_above", gw);
    txn(0, 1'b1, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_below", gw);
    txn(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, "rd_word0_kept", gw);
    txn(0, 1'b1, 32'h1000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, "wr_last", gw);
    txn(0, 1'b0, 32'h1000_0FFC, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, "rd_last", gw);
  endtask

  task automatic test_be_zero();
    int gw;
    txn(0, 1'b1, 32'h1000_0010, 32'h0000_0000, 4'h0, 32'h0, 1'b0, "wr_be0", gw);
    txn(0, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, "rd_be0", gw);
  endtask

  task automatic test_back_to_back();
    int gw, ng, nv;
    int tg [3];
    int tv [3];
    bit g;
    logic [32:0] e;
    logic [31:0] vals [3] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222};
    for (int i = 0; i < 3; i++)
      txn(1, 1'b1, 32'h1000_0000 + 32'(4 * i), vals[i], 4'hF, 32'h0, 1'b0, "b2b_preload", gw);
    ng = 0; nv = 0;
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h1000_0000;
    for (int k = 0; k < 12 && nv < 3; k++) begin
      @(negedge clk);
      g = gnt[1];
      if (rvalid[1]) begin
        if (sb_q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_spurious_rvalid at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (rdata[1] !== e[31:0] || err[1] !== e[32]) begin
            failures++;
            $display("FAIL b2b_rdata%0d got=%h/%b exp=%h/%b", nv, rdata[1], err[1], e[31:0], e[32]);
          end
          tv[nv] = cyc; nv++;
        end
      end
      if (g && ng < 3) begin
        sb_q.push_back({1'b0, vals[ng]});
        tg[ng] = cyc; ng++;
      end
      @(posedge clk); #1;
      if (g) begin
        if (ng >= 3) req[1] = 1'b0;
        else         addr[1] = 32'h1000_0000 + 32'(4 * ng);
      end
    end
    req[1] = 1'b0;
    checks++;
    if (ng != 3 || nv != 3) begin
      failures++; $display("FAIL b2b_count grants=%0d rvalids=%0d exp 3/3", ng, nv);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (tg[i] != tg[0] + 2 * i) begin
          failures++; $display("FAIL b2b_gnt_time%0d got=%0d exp=%0d", i, tg[i] - tg[0], 2 * i);
        end
        if (tv[i] != tg[i] + 1) begin
          failures++; $display("FAIL b2b_rvalid_time%0d got=%0d exp=%0d", i, tv[i] - tg[i], 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int gw;
    bit got;
    txn(2, 1'b1, 32'h1000_0020, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "w3_preload", gw);
    got = 0;
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h1000_0020; wdata[2] = 32'h5555_5555; be[2] = 4'hF;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt[2]) got = 1;
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    checks++;
    if (!got) begin
      failures++; $display("FAIL rst_wait_gnt: no grant within 20 cycles");
    end
    // One WAIT cycle has elapsed; reset lands before RESP would be entered
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rvalid[2] !== 1'b0) begin
        failures++; $display("FAIL rst_wait_no_rvalid got=%b exp=0 at k=%0d", rvalid[2], k);
      end
    end
    txn(2, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 32'h1234_5678, 1'b0, "rst_wait_old_data", gw);
    checks++;
    if (gw != 0) begin
      failures++; $display("FAIL rst_wait_idle grant_delay got=%0d exp=0", gw);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_be_zero();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
